if_pcgen: RTL and testbench
===========================

# if_pcgen

Instruction-fetch PC generator that sits directly upstream of the instruction memory. Each cycle it drives the word address and main/ISR bank select. It maintains the fetch PC with sequential advance, stall hold, branch/jump redirect, and single-level interrupt entry and return. Interrupt entry saves a return PC and switches fetch to the ISR ROM bank; return restores it.

## Interface
- PC_W, 12, fetch PC / instruction-memory byte-address width
- RESET_PC, 12'h000, main-bank PC loaded on reset
- ISR_BASE, 12'h000, ISR-bank PC loaded on interrupt entry

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC (sequential advance suppressed)
- inc_half  in  1  current instruction is 16-bit (from decoder), PC+2 instead of PC+4
- redirect_en  in  1  branch/jump taken, load redirect_pc
- redirect_pc  in  PC_W  redirect target
- int_req  in  1  interrupt request pulse or level
- isr_ret  in  1  return-from-ISR executed
- addr  out  PC_W  fetch byte address to instruction memory (registered PC)
- sel_ISR  out  1  1 = fetch from ISR bank
- int_ack  out  1  one-cycle pulse on interrupt entry
- ret_pc  out  PC_W  saved return PC (debug/visibility)

## Operation
- State: MAIN (sel_ISR=0) and ISR (sel_ISR=1); one-bit pending-interrupt flag; PC register; ret_pc register.
- pending set on any cycle with int_req=1; cleared only on entry. Requests during ISR or stall are held, not dropped. Repeated requests while pending collapse into one.
- Increment: inc = inc_half ? 2 : 4. Arithmetic is modulo 2^PC_W, so wrap-around from 12'hFFC+4 gives 12'h000.
- MAIN priority, highest first:
  - pending & !stall: enter ISR. ret_pc <= redirect_en ? redirect_pc : PC+inc; PC <= ISR_BASE; state ISR; int_ack=1 next cycle.
  - redirect_en: PC <= redirect_pc. This applies even when stalled.
  - !stall: PC <= PC+inc.
  - else hold.
- ISR priority, highest first:
  - isr_ret: PC <= ret_pc; state MAIN. This applies even when stalled.
  - redirect_en: PC <= redirect_pc.
  - !stall: PC <= PC+inc.
  - else hold.
- No nesting. A request arriving in ISR is serviced after return, on the first non-stalled MAIN cycle. Exactly one main-bank fetch, at ret_pc, occurs before re-entry; the saved return PC is then ret_pc+inc.
- isr_ret in MAIN is ignored.
- redirect_pc[0] is forced to 0.

## Timing
- Reset values: addr=RESET_PC, sel_ISR=0, int_ack=0, ret_pc=0, pending=0, state MAIN.
- Reset mid-ISR returns immediately to MAIN at RESET_PC and discards pending.
- addr and sel_ISR are registered. A decision made at rising edge N is visible after edge N.
- The instruction memory samples on the falling edge, so the instruction for addr is valid before edge N+1. No extra fetch bubble.
- int_req sampled at edge N with MAIN and !stall: pending is set at N, entry happens at N+1, and sel_ISR=1 and int_ack=1 during cycle N+1..N+2. Total latency is 2 cycles.
- int_ack is high exactly one cycle per entry.
- stall=1 indefinitely with no redirect: addr is constant and pending is held.

## Configuration
- IF_COMPRESSED_EN defined: inc_half is honoured, so PC may be halfword aligned.
- IF_COMPRESSED_EN not defined:
  - inc_half is ignored and the increment is always 4.
  - redirect_pc[1:0] and the stored ret_pc[1:0] are forced to 0.
  - addr[1:0] is always 0.

## Test plan
- Reset, then 4 free-running cycles: addr = 000, 004, 008, 00C; sel_ISR=0.
- With IF_COMPRESSED_EN, inc_half=1 at addr 008: next addr=00A. Without the macro: next addr=00C.
- redirect_en with redirect_pc=0x120 during stall=1: next addr=0x120, then holds while stall stays 1.
- int_req pulse at addr 0x040, no stall: two cycles later sel_ISR=1, addr=ISR_BASE, int_ack pulses once, ret_pc=0x048. Then isr_ret: addr=0x048, sel_ISR=0.
- int_req during ISR and during stall=1: no entry until after return and stall released. Exactly one fetch at ret_pc precedes re-entry; the new ret_pc is ret_pc+4.
- rst asserted mid-ISR at addr ISR_BASE+8: immediately addr=RESET_PC, sel_ISR=0, int_ack=0, no pending entry afterwards.

Source files
------------

// File: rtl/if_pcgen_if.sv
// if_pcgen_if: fetch-side bundle between the PC generator and its neighbours.
// master: decode/branch/interrupt side driving controls and observing the fetch address.
// slave : the PC generator itself.
interface if_pcgen_if #(
    parameter int unsigned PC_W = 12
);
    logic            stall;
    logic            inc_half;
    logic            redirect_en;
    logic [PC_W-1:0] redirect_pc;
    logic            int_req;
    logic            isr_ret;
    logic [PC_W-1:0] addr;
    logic            sel_ISR;
    logic            int_ack;
    logic [PC_W-1:0] ret_pc;

    modport master (
        output stall, inc_half, redirect_en, redirect_pc, int_req, isr_ret,
        input  addr, sel_ISR, int_ack, ret_pc
    );

    modport slave (
        input  stall, inc_half, redirect_en, redirect_pc, int_req, isr_ret,
        output addr, sel_ISR, int_ack, ret_pc
    );
endinterface

// File: rtl/if_pcgen.sv
// if_pcgen: instruction-fetch PC generator with single-level interrupt entry/return.
// Optional feature macro: IF_COMPRESSED_EN (halfword-aligned PC, honours inc_half).
// Without it every PC is word aligned and the increment is always 4.
module if_pcgen #(
    parameter int unsigned     PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] ISR_BASE = '0
) (
    input logic       clk,
    input logic       rst,
    if_pcgen_if.slave bus
);

    typedef enum logic {
        ST_MAIN = 1'b0,
        ST_ISR  = 1'b1
    } state_t;

`ifdef IF_COMPRESSED_EN
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(1);
`else
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
`endif

    localparam logic [PC_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
    localparam logic [PC_W-1:0] ISR_BASE_A = ISR_BASE & ALIGN_MASK;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] ret_q;
    logic            pending;
    logic            ack_q;

    logic [PC_W-1:0] inc_amt;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] redir_tgt;
    logic            take_int;

    // Sequential step size; the decoder's halfword hint only matters in the compressed build.
`ifdef IF_COMPRESSED_EN
    assign inc_amt = bus.inc_half ? PC_W'(2) : PC_W'(4);
`else
    logic unused_inc_half;
    assign unused_inc_half = bus.inc_half;
    assign inc_amt         = PC_W'(4);
`endif

    // Next sequential PC wraps naturally modulo 2^PC_W; redirect target is forced aligned.
    assign pc_seq    = pc + inc_amt;
    assign redir_tgt = bus.redirect_pc & ALIGN_MASK;

    // Entry happens only from the main bank, and only on a non-stalled cycle.
    assign take_int  = (state == ST_MAIN) && pending && !bus.stall;

    // PC / bank state machine, pending-interrupt flag and entry acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_MAIN;
            pc      <= RESET_PC_A;
            ret_q   <= '0;
            pending <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            // Requests are latched on any cycle and only consumed by an actual entry.
            if (bus.int_req) begin
                pending <= 1'b1;
            end
            case (state)
                ST_MAIN: begin
                    if (take_int) begin
                        ret_q   <= (bus.redirect_en ? redir_tgt : pc_seq) & ALIGN_MASK;
                        pc      <= ISR_BASE_A;
                        state   <= ST_ISR;
                        ack_q   <= 1'b1;
                        pending <= 1'b0;
                    end else if (bus.redirect_en) begin
                        pc <= redir_tgt;
                    end else if (!bus.stall) begin
                        pc <= pc_seq;
                    end
                end
                ST_ISR: begin
                    if (bus.isr_ret) begin
                        pc    <= ret_q;
                        state <= ST_MAIN;
                    end else if (bus.redirect_en) begin
                        pc <= redir_tgt;
                    end else if (!bus.stall) begin
                        pc <= pc_seq;
                    end
                end
                default: begin
                    state <= ST_MAIN;
                    pc    <= RESET_PC_A;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign bus.addr    = pc;
    assign bus.sel_ISR = (state == ST_ISR);
    assign bus.int_ack = ack_q;
    assign bus.ret_pc  = ret_q;

endmodule

// File: tb/tb_if_pcgen.sv
// tb_if_pcgen: directed-vector bench for if_pcgen (ISR_BASE placed at 0x800 to be distinguishable).
module tb_if_pcgen;

    localparam int unsigned PC_W = 12;
    localparam logic [11:0] ISR_B = 12'h800;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    if_pcgen_if #(.PC_W(PC_W)) bus ();

    if_pcgen #(
        .PC_W    (PC_W),
        .RESET_PC(12'h000),
        .ISR_BASE(ISR_B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [11:0] a, input logic s, input logic k);
        check({tag, ".addr"}, 32'(bus.addr), 32'(a));
        check({tag, ".sel"}, 32'(bus.sel_ISR), 32'(s));
        check({tag, ".ack"}, 32'(bus.int_ack), 32'(k));
    endtask

    initial begin
        n_vec           = 0;
        n_bad           = 0;
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.inc_half    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        bus.int_req     = 1'b0;
        bus.isr_ret     = 1'b0;

        step();
        step();
        chk_state("reset", 12'h000, 1'b0, 1'b0);
        check("reset.ret", 32'(bus.ret_pc), 32'h0);

        // Free-running fetch
        rst = 1'b0;
        chk_state("run0", 12'h000, 1'b0, 1'b0);
        step(); chk_state("run1", 12'h004, 1'b0, 1'b0);
        step(); chk_state("run2", 12'h008, 1'b0, 1'b0);

        // Halfword hint at 0x008
        bus.inc_half = 1'b1;
        step();
`ifdef IF_COMPRESSED_EN
        check("inc_half", 32'(bus.addr), 32'h00A);
`else
        check("inc_half", 32'(bus.addr), 32'h00C);
`endif
        bus.inc_half = 1'b0;

        // Redirect under stall, then hold
        bus.stall       = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 12'h120;
        step(); check("redir_stall", 32'(bus.addr), 32'h120);
        bus.redirect_en = 1'b0;
        step(); check("stall_hold1", 32'(bus.addr), 32'h120);
        step(); check("stall_hold2", 32'(bus.addr), 32'h120);
        bus.stall = 1'b0;

        // Odd/unaligned redirect target gets low bits forced
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 12'h043;
        step();
`ifdef IF_COMPRESSED_EN
        check("redir_align", 32'(bus.addr), 32'h042);
        bus.redirect_pc = 12'h040;
        step();
`else
        check("redir_align", 32'(bus.addr), 32'h040);
`endif
        bus.redirect_en = 1'b0;

        // Interrupt pulse at 0x040: two-cycle latency, ret_pc = 0x048
        bus.int_req = 1'b1;
        step(); chk_state("int_n", 12'h044, 1'b0, 1'b0);
        bus.int_req = 1'b0;
        step(); chk_state("int_entry", ISR_B, 1'b1, 1'b1);
        check("int_ret", 32'(bus.ret_pc), 32'h048);
        step(); chk_state("isr_run", 12'h804, 1'b1, 1'b0);
        bus.isr_ret = 1'b1;
        step(); chk_state("isr_return", 12'h048, 1'b0, 1'b0);
        bus.isr_ret = 1'b0;

        // Second entry from 0x04C, ret_pc = 0x050
        bus.int_req = 1'b1;
        step();
        bus.int_req = 1'b0;
        step(); chk_state("int2_entry", ISR_B, 1'b1, 1'b1);
        check("int2_ret", 32'(bus.ret_pc), 32'h050);

        // Request while in ISR is held, no nesting
        bus.int_req = 1'b1;
        step(); chk_state("isr_req", 12'h804, 1'b1, 1'b0);
        bus.int_req = 1'b0;
        step(); chk_state("isr_nonest", 12'h808, 1'b1, 1'b0);

        // Return while stalled still applies; pending waits for stall release
        bus.stall = 1'b1;
        step(); check("isr_stall", 32'(bus.addr), 32'h808);
        bus.isr_ret = 1'b1;
        step(); chk_state("ret_stall", 12'h050, 1'b0, 1'b0);
        bus.isr_ret = 1'b0;
        bus.int_req = 1'b1;
        step(); chk_state("pend_stall1", 12'h050, 1'b0, 1'b0);
        bus.int_req = 1'b0;
        step(); chk_state("pend_stall2", 12'h050, 1'b0, 1'b0);
        bus.stall = 1'b0;
        step(); chk_state("reentry", ISR_B, 1'b1, 1'b1);
        check("reentry_ret", 32'(bus.ret_pc), 32'h054);
        step(); chk_state("reentry_1", 12'h804, 1'b1, 1'b0);

        // Reset mid-ISR at ISR_BASE+8 with a request pending
        bus.int_req = 1'b1;
        step(); chk_state("pre_rst", 12'h808, 1'b1, 1'b0);
        bus.int_req = 1'b0;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 12'h000, 1'b0, 1'b0);
        check("async_rst.ret", 32'(bus.ret_pc), 32'h0);
        step();
        rst = 1'b0;
        step(); chk_state("post_rst1", 12'h004, 1'b0, 1'b0);
        step(); chk_state("post_rst2", 12'h008, 1'b0, 1'b0);

        // isr_ret in main bank is ignored
        bus.isr_ret = 1'b1;
        step(); chk_state("ret_in_main", 12'h00C, 1'b0, 1'b0);
        bus.isr_ret = 1'b0;

        // Wrap-around at the top of the address space
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 12'hFFC;
        step(); check("wrap_pre", 32'(bus.addr), 32'hFFC);
        bus.redirect_en = 1'b0;
        step(); chk_state("wrap", 12'h000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
